// File: rtl/z80_rom_fetch.sv
// Sound-CPU program fetch controller: Z80 ROM reads below $F800 through four bank windows to a shared SDRAM word port.
// Optional one-word fetch buffer enabled by defining Z80_FETCH_BUF_EN.
module z80_rom_fetch #(
  parameter int                 ADDR_W   = 22,
  parameter logic [ADDR_W-1:0]  ROM_BASE = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       SDA,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nSDRD,
  output logic              nZ80WAIT,
  output logic [7:0]        Z80_DOUT,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_DATA,
  output logic [1:0]        state_dbg
);

  // Handshake: MEM_REQ is a level held from REQ entry until the cycle MEM_ACK is seen;
  // MEM_ADDR is stable for that whole interval and MEM_DATA is only taken in the ACK cycle.
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t            state, state_next;
  logic [7:0]        bank0, bank1, bank2, bank3;
  logic              romrd, io_rd, io_q, bank_wr;
  logic [21:0]       xlat;
  logic [ADDR_W-1:0] tgt;
  logic              load_addr, load_ack, load_hit;
  logic              buf_hit;
  logic [7:0]        hit_byte;

  assign romrd   = !nMREQ && !nSDRD && (SDA < 16'hF800);
  assign io_rd   = !nIORQ && !nSDRD;
  assign bank_wr = io_rd && !io_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      io_q  <= 1'b0;
      bank0 <= 8'd2;
      bank1 <= 8'd6;
      bank2 <= 8'd14;
      bank3 <= 8'd30;
    end else begin
      io_q <= io_rd;
      if (bank_wr) begin
        case (SDA[3:0])
          4'h8:    bank3 <= SDA[15:8];
          4'h9:    bank2 <= SDA[15:8];
          4'hA:    bank1 <= SDA[15:8];
          4'hB:    bank0 <= SDA[15:8];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    xlat = {7'd0, SDA[14:0]};
    if (SDA[15]) begin
      if (!SDA[14])      xlat = {bank0, SDA[13:0]};
      else if (!SDA[13]) xlat = {1'b0, bank1, SDA[12:0]};
      else if (!SDA[12]) xlat = {2'b0, bank2, SDA[11:0]};
      else               xlat = {3'b0, bank3, SDA[10:0]};
    end
  end

  assign tgt = ADDR_W'(xlat) + ROM_BASE;

`ifdef Z80_FETCH_BUF_EN
  logic              buf_valid;
  logic [ADDR_W-2:0] buf_tag;
  logic [15:0]       buf_data;

  assign buf_hit  = buf_valid && (buf_tag == tgt[ADDR_W-1:1]);
  assign hit_byte = SDA[0] ? buf_data[15:8] : buf_data[7:0];

  // A bank write wins over a same-cycle fill so no stale mapping can survive.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_valid <= 1'b0;
    end else if (bank_wr) begin
      buf_valid <= 1'b0;
    end else if (load_ack) begin
      buf_valid <= 1'b1;
      buf_tag   <= MEM_ADDR[ADDR_W-1:1];
      buf_data  <= MEM_DATA;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign hit_byte = 8'hFF;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // IDLE starts on romrd level, which also picks up a read that began while DRAIN was finishing.
  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    load_ack   = 1'b0;
    load_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (romrd) begin
          if (buf_hit) begin
            state_next = HOLD;
            load_hit   = 1'b1;
          end else begin
            state_next = REQ;
            load_addr  = 1'b1;
          end
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          if (romrd) begin
            state_next = HOLD;
            load_ack   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (!romrd) begin
          state_next = DRAIN;
        end
      end
      HOLD:    if (!romrd) state_next = IDLE;
      DRAIN:   if (MEM_ACK) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_ADDR <= '0;
      Z80_DOUT <= 8'hFF;
    end else begin
      if (load_addr) MEM_ADDR <= {tgt[ADDR_W-1:1], 1'b0};
      if (load_ack)  Z80_DOUT <= SDA[0] ? MEM_DATA[15:8] : MEM_DATA[7:0];
      else if (load_hit) Z80_DOUT <= hit_byte;
    end
  end

  assign MEM_REQ   = ((state == REQ) || (state == DRAIN)) && !RESET;
  assign nZ80WAIT  = !(romrd && (state != HOLD));
  assign state_dbg = state;

endmodule

// File: tb/tb_z80_rom_fetch.sv
// Self-checking bench for z80_rom_fetch: random ROM reads, bank writes, drain, reset and buffer scenarios
// checked against a bank-arithmetic reference model and an expected-byte queue.
module tb_z80_rom_fetch;
  localparam int          ADDR_W   = 22;
  localparam logic [21:0] ROM_BASE = 22'h100000;

  logic              CLK, RESET;
  logic [15:0]       SDA;
  logic              nMREQ, nIORQ, nSDRD;
  logic              nZ80WAIT;
  logic [7:0]        Z80_DOUT;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_ACK;
  logic [15:0]       MEM_DATA;
  logic [1:0]        state_dbg;

  z80_rom_fetch #(.ADDR_W(ADDR_W), .ROM_BASE(ROM_BASE)) dut (
    .CLK(CLK), .RESET(RESET), .SDA(SDA), .nMREQ(nMREQ), .nIORQ(nIORQ), .nSDRD(nSDRD),
    .nZ80WAIT(nZ80WAIT), .Z80_DOUT(Z80_DOUT), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // reference model
  int         bank_m[4];
  bit         buf_v;
  int         buf_w;
  logic [7:0] dout_m;
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    bank_m[0] = 2; bank_m[1] = 6; bank_m[2] = 14; bank_m[3] = 30;
    buf_v  = 1'b0;
    dout_m = 8'hFF;
  endfunction

  function automatic int rom_addr(input int a);
    int x;
    if (a < 'h8000)      x = a;
    else if (a < 'hC000) x = bank_m[0] * 'h4000 + (a - 'h8000);
    else if (a < 'hE000) x = bank_m[1] * 'h2000 + (a - 'hC000);
    else if (a < 'hF000) x = bank_m[2] * 'h1000 + (a - 'hE000);
    else                 x = bank_m[3] * 'h800  + (a - 'hF000);
    return (x + int'(ROM_BASE)) % (1 << ADDR_W);
  endfunction

  function automatic logic [15:0] mem_word(input int byte_addr);
    int w;
    w = byte_addr >> 1;
    return 16'((w * 40503) ^ (w >> 3) ^ 'h5A3C);
  endfunction

  function automatic bit buf_enabled();
`ifdef Z80_FETCH_BUF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic release_bus();
    nMREQ = 1'b1; nIORQ = 1'b1; nSDRD = 1'b1; MEM_ACK = 1'b0;
  endtask

  task automatic do_io(input logic [3:0] port, input logic [7:0] val);
    SDA = {val, 4'($urandom_range(0, 15)), port};
    nIORQ = 1'b0; nSDRD = 1'b0;
    #1;
    checks++;
    if (nZ80WAIT !== 1'b1 || MEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL io_no_wait: port %0h wait=%b req=%b expected wait=1 req=0", port, nZ80WAIT, MEM_REQ);
    end
    tick();
    nIORQ = 1'b1; nSDRD = 1'b1;
    tick();
    case (port)
      4'h8: bank_m[3] = int'(val);
      4'h9: bank_m[2] = int'(val);
      4'hA: bank_m[1] = int'(val);
      4'hB: bank_m[0] = int'(val);
      default: ;
    endcase
    if (port >= 4'h8 && port <= 4'hB) buf_v = 1'b0;
  endtask

  // One ROM read; on a miss MEM_ACK is driven k cycles after the cycle in which romrd rises.
  task automatic do_read(input logic [15:0] a, input int k);
    int          ea, ew, waits, reqs, n;
    bit          hit, addr_bad;
    logic [15:0] word;
    logic [7:0]  exp_b;
    ea = rom_addr(int'(a));
    ew = ea & ~1;
    word = mem_word(ew);
    hit = buf_enabled() && buf_v && (buf_w == ew);
    exp_q.push_back(a[0] ? word[15:8] : word[7:0]);
    waits = 0; reqs = 0; addr_bad = 1'b0;
    n = hit ? 3 : k + 3;
    SDA = a; nMREQ = 1'b0; nSDRD = 1'b0;
    for (int i = 0; i < n; i++) begin
      MEM_ACK  = !hit && (i == k);
      MEM_DATA = (i == k) ? word : 16'($urandom);
      #1;
      if (nZ80WAIT === 1'b0) waits++;
      if (MEM_REQ === 1'b1) reqs++;
      if (!hit && i >= 1 && i <= k && MEM_ADDR !== ADDR_W'(ew)) addr_bad = 1'b1;
      tick();
    end
    MEM_ACK = 1'b0;
    exp_b = exp_q.pop_front();
    checks++;
    if (waits != (hit ? 1 : k + 1)) begin
      errors++;
      $display("FAIL read_wait_len: addr %04h wait cycles %0d expected %0d", a, waits, hit ? 1 : k + 1);
    end
    checks++;
    if (reqs != (hit ? 0 : k)) begin
      errors++;
      $display("FAIL read_req_len: addr %04h req cycles %0d expected %0d", a, reqs, hit ? 0 : k);
    end
    checks++;
    if (addr_bad) begin
      errors++;
      $display("FAIL read_mem_addr: addr %04h mem_addr %06h expected %06h", a, MEM_ADDR, ew);
    end
    checks++;
    if (Z80_DOUT !== exp_b || nZ80WAIT !== 1'b1) begin
      errors++;
      $display("FAIL read_data: addr %04h dout %02h wait %b expected dout %02h wait 1", a, Z80_DOUT, nZ80WAIT, exp_b);
    end
    dout_m = exp_b;
    if (!hit) begin
      buf_v = 1'b1;
      buf_w = ew;
    end
    nMREQ = 1'b1; nSDRD = 1'b1;
    SDA = 16'($urandom);
    tick();
    checks++;
    if (Z80_DOUT !== dout_m || MEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL read_release: dout %02h req %b expected dout %02h req 0", Z80_DOUT, MEM_REQ, dout_m);
    end
  endtask

  // scenarios
  task automatic test_reset();
    release_bus();
    SDA = 16'h0000; MEM_DATA = 16'h0000;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || MEM_ADDR !== '0 || Z80_DOUT !== 8'hFF || nZ80WAIT !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: req %b addr %06h dout %02h wait %b expected 0 000000 ff 1",
               MEM_REQ, MEM_ADDR, Z80_DOUT, nZ80WAIT);
    end
    tick();
  endtask

  task automatic test_basic();
    do_read(16'h8123, 2);
    do_read(16'h0040, 1);
  endtask

  task automatic test_bank_write();
    do_io(4'hA, 8'h05);
    do_read(16'hC010, 1);
    do_io(4'h8, 8'h41);
    do_read(16'hF3A7, 3);
  endtask

  task automatic test_long_ack();
    do_read(16'($urandom_range(0, 'h7FFF)), 10);
  endtask

  task automatic test_ram_io();
    bit bad;
    bad = 1'b0;
    SDA = 16'hF900; nMREQ = 1'b0; nSDRD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (nZ80WAIT !== 1'b1 || MEM_REQ !== 1'b0) bad = 1'b1;
      tick();
    end
    nMREQ = 1'b1; nSDRD = 1'b1;
    tick();
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ram_no_fetch: wait %b req %b expected wait 1 req 0", nZ80WAIT, MEM_REQ);
    end
    do_io(4'h4, 8'h77);
    do_read(16'h8AB1, 1);
    do_read(16'hC3C2, 1);
    do_read(16'hE555, 2);
    do_read(16'hF010, 1);
  endtask

  task automatic test_drain();
    int          eb;
    logic [15:0] word_b;
    logic [15:0] b;
    bit          seen;
    do_io(4'hB, 8'(bank_m[0]));
    SDA = 16'h1234; nMREQ = 1'b0; nSDRD = 1'b0;
    tick();
    tick();
    nMREQ = 1'b1; nSDRD = 1'b1;
    #1;
    checks++;
    if (nZ80WAIT !== 1'b1 || MEM_REQ !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold_req: wait %b req %b expected wait 1 req 1", nZ80WAIT, MEM_REQ);
    end
    tick();
    b = 16'h2468;
    eb = rom_addr(int'(b));
    word_b = mem_word(eb);
    SDA = b; nMREQ = 1'b0; nSDRD = 1'b0;
    MEM_ACK = 1'b1; MEM_DATA = 16'hDEAD;
    #1;
    checks++;
    if (nZ80WAIT !== 1'b0 || MEM_REQ !== 1'b1) begin
      errors++;
      $display("FAIL drain_ack_edge: wait %b req %b expected wait 0 req 1", nZ80WAIT, MEM_REQ);
    end
    tick();
    MEM_ACK = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (MEM_REQ === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen || MEM_ADDR !== ADDR_W'(eb & ~1) || Z80_DOUT !== dout_m) begin
      errors++;
      $display("FAIL drain_next_req: seen %b addr %06h dout %02h expected addr %06h dout %02h",
               seen, MEM_ADDR, Z80_DOUT, eb & ~1, dout_m);
    end
    MEM_ACK = 1'b1; MEM_DATA = word_b;
    tick();
    MEM_ACK = 1'b0;
    #1;
    checks++;
    if (Z80_DOUT !== word_b[7:0] || nZ80WAIT !== 1'b1) begin
      errors++;
      $display("FAIL drain_next_data: dout %02h wait %b expected dout %02h wait 1", Z80_DOUT, nZ80WAIT, word_b[7:0]);
    end
    dout_m = word_b[7:0];
    buf_v = 1'b1; buf_w = eb & ~1;
    nMREQ = 1'b1; nSDRD = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    do_io(4'hA, 8'h09);
    SDA = 16'hC777; nMREQ = 1'b0; nSDRD = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b1;
    nMREQ = 1'b1; nSDRD = 1'b1;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_req: req %b expected 0", MEM_REQ);
    end
    tick();
    RESET = 1'b0;
    model_reset();
    MEM_ACK = 1'b1; MEM_DATA = 16'hBEEF;
    tick();
    MEM_ACK = 1'b0;
    tick();
    checks++;
    if (MEM_REQ !== 1'b0 || Z80_DOUT !== 8'hFF || nZ80WAIT !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: req %b dout %02h wait %b expected 0 ff 1", MEM_REQ, Z80_DOUT, nZ80WAIT);
    end
    do_read(16'hC777, 2);
    do_read(16'h9001, 1);
  endtask

  task automatic test_buffer();
    do_io(4'h9, 8'(bank_m[2]));
    do_read(16'h0100, 2);
    do_read(16'h0101, 2);
    do_io(4'hB, 8'h11);
    do_read(16'h0100, 1);
    do_io(4'hB, 8'h12);
    do_read(16'h0101, 1);
  endtask

  task automatic test_random();
    logic [15:0] last_a;
    logic [15:0] a;
    last_a = 16'h0200;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 9))
        0, 1: do_io(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        2, 3: do_read(last_a ^ 16'h0001, $urandom_range(1, 4));
        default: begin
          a = 16'($urandom_range(0, 'hF7FF));
          do_read(a, $urandom_range(1, 4));
          last_a = a;
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bank_write();
    test_long_ack();
    test_ram_io();
    test_drain();
    test_reset_mid();
    test_buffer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
